spi_master: RTL and testbench

- SPI master (initiator) for single-byte, full-duplex transfers; the controller end of our SPI slave link.
- Generates SCLK from the system clock via a programmable divider and drives CS and MOSI. Samples MISO and returns the received byte with a one-cycle done pulse.
- Supports all four CPOL/CPHA modes. Mode is selected per transfer.

---
 rtl/spi_master.sv | 194 +++++++++++++++++++
 tb/tb_spi_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master for single-word full-duplex transfers in any CPOL/CPHA mode.
// Optional macro SPI_MASTER_LSB_FIRST_EN adds a per-transfer lsb_first input.
module spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              CPOL,
  input  logic              CPHA,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned EDGES  = 2 * DATA_W;
  localparam int unsigned EDGE_W = $clog2(EDGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TRANSFER,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              lead;
  logic              edge_ev;
  logic              lsb_new;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_new = lsb_first;
`else
  assign lsb_new = 1'b0;
`endif

  assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));
  // The edge about to be generated is odd-numbered (leading) when edge_q is even.
  assign lead = ~edge_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    edge_ev = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = CPOL;
        if (start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          lsb_d   = lsb_new;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          tx_d    = data_in;
          // CPHA=0 needs the first bit on the wire before the first leading edge.
          if (!CPHA) begin
            mosi_d = lsb_new ? data_in[0] : data_in[DATA_W-1];
            tx_d   = lsb_new ? (data_in >> 1) : (data_in << 1);
          end
        end
      end
      S_SETUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
          state_d = S_TRANSFER;
          edge_ev = 1'b1;
        end
      end
      S_TRANSFER: begin
        if (edge_q == EDGE_W'(EDGES)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (tick) edge_ev = 1'b1;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
          state_d = S_DONE;
          cnt_d   = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = rx_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // SCLK edge: sample on one edge type, shift/drive on the other.
    if (edge_ev) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
      edge_d = edge_q + EDGE_W'(1);
      if (lead ^ cpha_q) begin
        rx_d = lsb_q ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
      end else if (cpha_q || (edge_q != EDGE_W'(EDGES - 1))) begin
        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS       = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table vectors, random transfers against an
// edge-counting slave model, plus held-start, mid-transfer reset and divide-by-5 cases.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned W = 8;

  typedef struct {
    logic         pol;
    logic         pha;
    logic [W-1:0] tx;
    logic [W-1:0] srx;
    logic [W-1:0] exp_rx;
    int           exp_done;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_a, start_b;
  logic [W-1:0] data_in;
  logic         cpol_in, cpha_in, miso;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic         lsb_in;
`endif
  logic         sclk_a, mosi_a, cs_a, busy_a, done_a;
  logic [W-1:0] dout_a;
  logic         sclk_b, mosi_b, cs_b, busy_b, done_b;
  logic [W-1:0] dout_b;

  int n_cmp = 0;
  int n_bad = 0;

  spi_master #(.CLK_DIV(2), .DATA_W(W)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_in(data_in),
    .CPOL(cpol_in), .CPHA(cpha_in),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_in),
`endif
    .MISO(miso), .SCLK(sclk_a), .MOSI(mosi_a), .CS(cs_a),
    .busy(busy_a), .done(done_a), .data_out(dout_a)
  );

  spi_master #(.CLK_DIV(5), .DATA_W(W)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_in(data_in),
    .CPOL(cpol_in), .CPHA(cpha_in),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_in),
`endif
    .MISO(miso), .SCLK(sclk_b), .MOSI(mosi_b), .CS(cs_b),
    .busy(busy_b), .done(done_b), .data_out(dout_b)
  );

  always #5 clk = ~clk;

  // Slave model: counts SCLK edges while selected, captures MOSI, serves s_tx.
  logic         use_b = 1'b0;
  logic         m_pha = 1'b0;
  logic         s_lsb = 1'b0;
  logic [W-1:0] s_tx = '0;
  logic [W-1:0] mosi_seq = '0;
  logic         prev_sclk = 1'b0;
  logic         prev_cs = 1'b1;
  int           n_edge = 0, n_lead = 0, n_trail = 0;
  int           cyc = 0, last_edge_cyc = 0, min_gap = 1000, max_gap = 0;

  wire         o_sclk = use_b ? sclk_b : sclk_a;
  wire         o_mosi = use_b ? mosi_b : mosi_a;
  wire         o_cs   = use_b ? cs_b   : cs_a;
  wire         o_busy = use_b ? busy_b : busy_a;
  wire         o_done = use_b ? done_b : done_a;
  wire [W-1:0] o_dout = use_b ? dout_b : dout_a;

  function automatic logic s_bit(input int idx);
    if (idx < 0 || idx >= int'(W)) return 1'b0;
    return s_lsb ? s_tx[idx] : s_tx[int'(W) - 1 - idx];
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = v[int'(W) - 1 - i];
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (o_cs === 1'b1) begin
      n_edge = 0; n_lead = 0; n_trail = 0; mosi_seq = '0;
      min_gap = 1000; max_gap = 0;
    end else if (prev_cs === 1'b0 && o_sclk !== prev_sclk) begin
      n_edge++;
      if (n_edge > 1) begin
        if (cyc - last_edge_cyc < min_gap) min_gap = cyc - last_edge_cyc;
        if (cyc - last_edge_cyc > max_gap) max_gap = cyc - last_edge_cyc;
      end
      last_edge_cyc = cyc;
      if (n_edge % 2 == 1) begin
        n_lead++;
        if (!m_pha) mosi_seq = {mosi_seq[W-2:0], o_mosi};
      end else begin
        n_trail++;
        if (m_pha) mosi_seq = {mosi_seq[W-2:0], o_mosi};
      end
    end
    miso = m_pha ? s_bit(n_lead - 1) : s_bit(n_trail);
    prev_sclk = o_sclk;
    prev_cs   = o_cs;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One transfer; k counts cycles after the acceptance cycle T.
  task automatic xfer(input string tag, input bit b, input logic pol, input logic pha,
                      input logic [W-1:0] tx, input logic [W-1:0] srx, input logic lsb,
                      input bit hold, input bit scramble,
                      input logic [W-1:0] exp_rx, input int exp_done);
    int           cd = b ? 5 : 2;
    int           done_k = -1, n_done = 0, cs_low = 0, cs_first = -1;
    int           edges_at = -1, gmin = 0, gmax = 0;
    logic [W-1:0] seq_at = '0, dout_at = '0;
    logic         sclk_k1 = 1'b0, busy_k1 = 1'b0, sclk_dn = 1'b0, busy_dn = 1'b1;
    use_b = b; m_pha = pha; s_tx = srx; s_lsb = lsb;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_in = lsb;
`endif
    cpol_in = pol; cpha_in = pha; data_in = tx;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    for (int k = 1; k <= exp_done + 8; k++) begin
      step();
      if (k == 1 && !hold) begin start_a = 1'b0; start_b = 1'b0; end
      if (k == 3 && scramble) begin
        data_in = W'($urandom); cpol_in = ~pol; cpha_in = ~pha;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_in = ~lsb;
`endif
      end
      if (k == 1) begin sclk_k1 = o_sclk; busy_k1 = o_busy; end
      if (done_k < 0 && o_cs === 1'b0) begin
        cs_low++;
        if (cs_first < 0) cs_first = k;
        edges_at = n_edge; seq_at = mosi_seq; gmin = min_gap; gmax = max_gap;
      end
      if (done_k > 0 && k == done_k + 1) begin
        chk({tag, "_done_pulse_width"}, 32'(o_done), 32'(1'b0));
        chk({tag, "_cs_after_done"}, 32'(o_cs), 32'(1'b1));
        break;
      end
      if (o_done === 1'b1) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k; dout_at = o_dout; sclk_dn = o_sclk; busy_dn = o_busy;
        end
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_k), 32'(exp_done));
    chk({tag, "_done_count"}, 32'(n_done), 32'(1));
    chk({tag, "_data_out"}, 32'(dout_at), 32'(exp_rx));
    chk({tag, "_mosi_bits"}, 32'(seq_at), 32'(lsb ? rev(tx) : tx));
    chk({tag, "_cs_first_low"}, 32'(cs_first), 32'(1));
    chk({tag, "_cs_low_cycles"}, 32'(cs_low), 32'(exp_done - 1));
    chk({tag, "_edge_count"}, 32'(edges_at), 32'(2 * W));
    chk({tag, "_half_period_min"}, 32'(gmin), 32'(cd));
    chk({tag, "_half_period_max"}, 32'(gmax), 32'(cd));
    chk({tag, "_sclk_at_setup"}, 32'(sclk_k1), 32'(pol));
    chk({tag, "_sclk_at_done"}, 32'(sclk_dn), 32'(pol));
    chk({tag, "_busy_at_setup"}, 32'(busy_k1), 32'(1'b1));
    chk({tag, "_busy_at_done"}, 32'(busy_dn), 32'(1'b0));
  endtask

  initial begin
    vec_t         tbl [4];
    logic [W-1:0] rt, rr;
    logic         rp, rh;
    bit           rb;
    int           cs_cnt, ab_done;

    start_a = 1'b0; start_b = 1'b0; data_in = '0;
    cpol_in = 1'b0; cpha_in = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_in = 1'b0;
`endif
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_cs", 32'(cs_a), 32'(1'b1));
    chk("reset_sclk", 32'(sclk_a), 32'(1'b0));
    chk("reset_mosi", 32'(mosi_a), 32'(1'b0));
    chk("reset_busy", 32'(busy_a), 32'(1'b0));
    chk("reset_done", 32'(done_a), 32'(1'b0));
    chk("reset_data_out", 32'(dout_a), 32'(0));
    chk("reset_cs_div5", 32'(cs_b), 32'(1'b1));
    step(); step();
    reset = 1'b1;
    step();

    tbl[0] = '{pol: 1'b0, pha: 1'b0, tx: 8'hA5, srx: 8'h3C, exp_rx: 8'h3C, exp_done: 36};
    tbl[1] = '{pol: 1'b0, pha: 1'b1, tx: 8'hA5, srx: 8'h3C, exp_rx: 8'h3C, exp_done: 36};
    tbl[2] = '{pol: 1'b1, pha: 1'b0, tx: 8'hA5, srx: 8'h3C, exp_rx: 8'h3C, exp_done: 36};
    tbl[3] = '{pol: 1'b1, pha: 1'b1, tx: 8'hA5, srx: 8'h3C, exp_rx: 8'h3C, exp_done: 36};

    foreach (tbl[i]) begin
      cpol_in = tbl[i].pol; cpha_in = tbl[i].pha;
      step(); step();
      chk($sformatf("vec%0d_idle_sclk_before", i), 32'(sclk_a), 32'(tbl[i].pol));
      xfer($sformatf("vec%0d", i), 1'b0, tbl[i].pol, tbl[i].pha, tbl[i].tx, tbl[i].srx,
           1'b0, 1'b0, 1'b0, tbl[i].exp_rx, tbl[i].exp_done);
      step();
      chk($sformatf("vec%0d_idle_sclk_after", i), 32'(sclk_a), 32'(tbl[i].pol));
    end

    for (int i = 0; i < 12; i++) begin
      rp = 1'($urandom); rh = 1'($urandom); rb = ($urandom_range(3) == 0);
      rt = W'($urandom); rr = W'($urandom);
      cpol_in = rp; cpha_in = rh;
      step(); step();
      xfer($sformatf("rnd%0d", i), rb, rp, rh, rt, rr, 1'b0, 1'b0, 1'b1,
           rr, 2 + (2 * int'(W) + 1) * (rb ? 5 : 2));
    end

    // Held start: back-to-back transfers with a 2-cycle CS-high gap, then none.
    cpol_in = 1'b1; cpha_in = 1'b0;
    step(); step();
    xfer("hold1", 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 36);
    xfer("hold2", 1'b0, 1'b1, 1'b0, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3, 36);
    cs_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (cs_a !== 1'b1) cs_cnt++;
    end
    chk("hold_no_extra_transfer", 32'(cs_cnt), 32'(0));

    // Reset pulsed at edge 7 of a mode-0 transfer.
    use_b = 1'b0; m_pha = 1'b0; s_tx = 8'h3C; s_lsb = 1'b0;
    cpol_in = 1'b0; cpha_in = 1'b0; data_in = 8'hA5;
    step(); step();
    start_a = 1'b1;
    ab_done = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) start_a = 1'b0;
      if (done_a === 1'b1) ab_done++;
    end
    chk("abort_edges_before_reset", 32'(n_edge), 32'(7));
    reset = 1'b0;
    #1;
    chk("abort_cs", 32'(cs_a), 32'(1'b1));
    chk("abort_sclk", 32'(sclk_a), 32'(1'b0));
    chk("abort_busy", 32'(busy_a), 32'(1'b0));
    for (int k = 0; k < 4; k++) begin
      step();
      if (done_a === 1'b1) ab_done++;
    end
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done_a === 1'b1) ab_done++;
    end
    chk("abort_no_done", 32'(ab_done), 32'(0));
    chk("abort_data_out", 32'(dout_a), 32'(0));
    xfer("after_reset", 1'b0, 1'b0, 1'b0, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 36);

    // Divide-by-5 instance, mode 3.
    cpol_in = 1'b1; cpha_in = 1'b1;
    step(); step();
    chk("div5_idle_sclk", 32'(sclk_b), 32'(1'b1));
    xfer("div5", 1'b1, 1'b1, 1'b1, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 87);

`ifdef SPI_MASTER_LSB_FIRST_EN
    cpol_in = 1'b0; cpha_in = 1'b0;
    step(); step();
    xfer("lsb_mode0", 1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 36);
    cpol_in = 1'b1; cpha_in = 1'b1;
    step(); step();
    xfer("lsb_mode3", 1'b0, 1'b1, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 36);
`endif

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
